trap_ctrl: RTL and testbench
============================

# trap_ctrl

Trap and return sequencer between the write-back stage and the CSR file / fetch unit. On an exception flush or `mret` retiring in WBU, it:
- flushes the pipeline;
- waits for the LSU to drain;
- performs the architectural CSR updates (mepc, mcause, mstatus) one per cycle over the shared CSR write port;
- hands the new PC to IFU with a valid/ready handshake.

When idle, it passes WBU's CSR writes straight through to the CSR file.

## Interface
Parameters:
- `WDOG_CYCLES`, 256: drain watchdog limit in cycles; used only when the watchdog is compiled in.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `excp_flush_i` in 1: WBU exception retire, one-cycle pulse.
- `mret_flush_i` in 1: WBU mret retire, one-cycle pulse.
- `mcause_i` in 32: cause code, valid with `excp_flush_i`.
- `mepc_i` in 32: faulting PC, valid with `excp_flush_i`.
- `csr_mtvec_i` in 32: current mtvec value (combinational read).
- `csr_mepc_i` in 32: current mepc value (combinational read).
- `csr_mstatus_i` in 32: current mstatus value (combinational read).
- `lsu_busy_i` in 1: LSU has an outstanding bus transaction.
- `wbu_csr_we_i` in 1: WBU CSR write enable.
- `wbu_csr_addr_i` in 12: WBU CSR write address.
- `wbu_csr_wdata_i` in 32: WBU CSR write data.
- `csr_we_o` out 1: CSR file write enable (muxed port).
- `csr_addr_o` out 12: CSR file write address (muxed port).
- `csr_wdata_o` out 32: CSR file write data (muxed port).
- `flush_o` out 1: kill all in-flight instructions in IFU..LSU.
- `busy_o` out 1: sequencer not in IDLE.
- `redirect_valid_o` out 1: new PC offered to IFU.
- `redirect_pc_o` out 32: new PC.
- `redirect_ready_i` in 1: IFU accepts the redirect.
- `wdog_fatal_o` out 1: drain watchdog expired (sticky).

## Operation
- States: IDLE, DRAIN, W_MEPC, W_MCAUSE, W_MSTATUS, REDIRECT.
- Event capture (IDLE only):
  - `excp_flush_i` latches kind=TRAP, `mepc_i`, `mcause_i`, and `csr_mtvec_i & ~32'h3` as target; go to DRAIN.
  - `mret_flush_i` latches kind=MRET and `csr_mepc_i` as target; go to DRAIN.
  - If both pulse in the same cycle, TRAP wins.
- Events in any non-IDLE state are ignored; the pipeline is already flushed.
- DRAIN: stay while `lsu_busy_i`=1. Otherwise go to W_MEPC (TRAP) or W_MSTATUS (MRET).
- W_MEPC: write addr 12'h341, data = latched mepc. Go to W_MCAUSE.
- W_MCAUSE: write addr 12'h342, data = latched mcause. Go to W_MSTATUS.
- W_MSTATUS: write addr 12'h300. Data is `csr_mstatus_i` with:
  - TRAP: bit7 (MPIE) ← bit3 (MIE), bit3 ← 0, bits[12:11] (MPP) ← 2'b11.
  - MRET: bit3 ← bit7, bit7 ← 1, bits[12:11] ← 2'b11.
  - All other bits unchanged.
  - Go to REDIRECT.
- REDIRECT: `redirect_valid_o`=1 and `redirect_pc_o`=target, both held stable until `redirect_ready_i`=1 at a rising edge; then go to IDLE.
- CSR port mux:
  - In IDLE, outputs equal the `wbu_csr_*_i` inputs, except `csr_we_o` is forced to 0 in a cycle where `excp_flush_i`=1 (a trapping instruction must not commit its CSR write).
  - In W_* states the sequencer owns the port.
  - In DRAIN and REDIRECT, `csr_we_o`=0 and WBU writes are dropped.
- `busy_o` = (state != IDLE).
- `flush_o` = `busy_o` | `excp_flush_i` | `mret_flush_i` (combinational, so upstream stages kill in the event cycle).

## Timing
- Reset (`reset`=0, asynchronous), all held until release:
  - state = IDLE; latched fields = 0.
  - `redirect_valid_o`=0, `redirect_pc_o`=0, `csr_we_o`=0, `busy_o`=0, `wdog_fatal_o`=0.
  - `flush_o` follows its combinational equation.
- Reset asserted mid-sequence aborts immediately to IDLE with no further CSR writes.
- TRAP, no drain stall, immediate ready (event sampled at cycle 0):
  - DRAIN c1, W_MEPC c2, W_MCAUSE c3, W_MSTATUS c4, REDIRECT c5, IDLE c6.
  - Latency is 5 cycles to `redirect_valid_o`.
- MRET, same conditions: DRAIN c1, W_MSTATUS c2, REDIRECT c3, IDLE c4.
- Each cycle that `lsu_busy_i`=1 in DRAIN adds one cycle.
- Each cycle that `redirect_ready_i`=0 in REDIRECT adds one cycle.
- A new event can be accepted in the first IDLE cycle after the handshake completes.

## Configuration
- `TRAP_CTRL_WDOG_EN` defined:
  - A 16-bit counter clears on DRAIN entry and increments each DRAIN cycle.
  - When it reaches `WDOG_CYCLES`, the FSM leaves DRAIN regardless of `lsu_busy_i`, and `wdog_fatal_o` sets.
  - `wdog_fatal_o` clears only on reset.
- Undefined:
  - No counter; DRAIN waits indefinitely.
  - `wdog_fatal_o` is tied to 0.

## Test plan
- ECALL trap: `excp_flush_i`=1, `mcause_i`=11, `mepc_i`=0x8000_0010, mtvec=0x8000_0101, mstatus=0x8 -> CSR writes 0x341←0x8000_0010 at c2, 0x342←11 at c3, 0x300←0x1880 at c4; redirect 0x8000_0100 at c5.
- MRET: mepc=0x8000_0014, mstatus=0x80 -> 0x300←0x1888 at c2; redirect 0x8000_0014 at c3; `busy_o` low at c4.
- Drain stall: trap with `lsu_busy_i` high for 3 cycles -> first CSR write at c5; `flush_o` high throughout c0..c7.
- Handshake back-pressure: `redirect_ready_i` low for 4 cycles -> valid and PC stable; a second `excp_flush_i` pulse during the wait is ignored; IDLE one cycle after ready.
- Passthrough and collision:
  - IDLE WBU write 0x305←0x1234 appears on the CSR port the same cycle.
  - The same write coincident with `excp_flush_i` yields `csr_we_o`=0.
- Async reset in W_MCAUSE -> IDLE, all outputs 0 immediately; with `TRAP_CTRL_WDOG_EN`, `WDOG_CYCLES`=8 and `lsu_busy_i` stuck high -> W_MEPC entered after 8 DRAIN cycles, `wdog_fatal_o`=1.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap/mret sequencer: flushes the pipeline, drains the LSU, writes mepc/mcause/mstatus, then redirects fetch.
// Optional drain watchdog compiled in with `define TRAP_CTRL_WDOG_EN.
module trap_ctrl #(
  parameter int unsigned WDOG_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        excp_flush_i,
  input  logic        mret_flush_i,
  input  logic [31:0] mcause_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic        lsu_busy_i,
  input  logic        wbu_csr_we_i,
  input  logic [11:0] wbu_csr_addr_i,
  input  logic [31:0] wbu_csr_wdata_i,
  output logic        csr_we_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic        flush_o,
  output logic        busy_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  output logic        wdog_fatal_o
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    REDIRECT
  } state_t;

  state_t      state_q, state_d;
  logic        is_trap_q;
  logic [31:0] mepc_q, mcause_q, target_q;
  logic [31:0] mstatus_upd;
  logic        wdog_expired;
  logic        drain_done;

`ifdef TRAP_CTRL_WDOG_EN
  logic [15:0] wdog_cnt_q;
  logic        wdog_fatal_q;

  // The counter sits at zero outside DRAIN, so it is cleared on every DRAIN entry.
  assign wdog_expired = (state_q == DRAIN) &&
                        ((32'(wdog_cnt_q) + 32'd1) >= WDOG_CYCLES);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdog_cnt_q   <= '0;
      wdog_fatal_q <= 1'b0;
    end else begin
      if (state_q != DRAIN) wdog_cnt_q <= '0;
      else                  wdog_cnt_q <= wdog_cnt_q + 16'd1;
      if (wdog_expired && lsu_busy_i) wdog_fatal_q <= 1'b1;
    end
  end

  assign wdog_fatal_o = wdog_fatal_q;
`else
  logic unused_wdog;
  assign unused_wdog  = ^WDOG_CYCLES;
  assign wdog_expired = 1'b0;
  assign wdog_fatal_o = 1'b0;
`endif

  assign drain_done = !lsu_busy_i || wdog_expired;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      is_trap_q <= 1'b0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      target_q  <= '0;
    end else begin
      state_q <= state_d;
      // Events are only captured in IDLE; a trap outranks a simultaneous mret.
      if (state_q == IDLE) begin
        if (excp_flush_i) begin
          is_trap_q <= 1'b1;
          mepc_q    <= mepc_i;
          mcause_q  <= mcause_i;
          target_q  <= csr_mtvec_i & ~32'h3;
        end else if (mret_flush_i) begin
          is_trap_q <= 1'b0;
          target_q  <= csr_mepc_i;
        end
      end
    end
  end

  always_comb begin
    mstatus_upd = csr_mstatus_i;
    if (is_trap_q) begin
      mstatus_upd[7] = csr_mstatus_i[3];
      mstatus_upd[3] = 1'b0;
    end else begin
      mstatus_upd[3] = csr_mstatus_i[7];
      mstatus_upd[7] = 1'b1;
    end
    mstatus_upd[12:11] = 2'b11;
  end

  always_comb begin
    state_d          = state_q;
    csr_we_o         = 1'b0;
    csr_addr_o       = '0;
    csr_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    case (state_q)
      IDLE: begin
        // A trapping instruction must not commit its own CSR write.
        csr_we_o    = wbu_csr_we_i & ~excp_flush_i;
        csr_addr_o  = wbu_csr_addr_i;
        csr_wdata_o = wbu_csr_wdata_i;
        if (excp_flush_i || mret_flush_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_d = is_trap_q ? W_MEPC : W_MSTATUS;
      end
      W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = 12'h341;
        csr_wdata_o = mepc_q;
        state_d     = W_MCAUSE;
      end
      W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = 12'h342;
        csr_wdata_o = mcause_q;
        state_d     = W_MSTATUS;
      end
      W_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = 12'h300;
        csr_wdata_o = mstatus_upd;
        state_d     = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
        if (redirect_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o  = (state_q != IDLE);
  assign flush_o = busy_o | excp_flush_i | mret_flush_i;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expected CSR writes and redirects are queued with their cycle
// numbers when an event is driven and compared by a monitor when the DUT produces them.
module tb_trap_ctrl;

  logic        clock;
  logic        reset;
  logic        excp_flush, mret_flush;
  logic [31:0] mcause, mepc;
  logic [31:0] csr_mtvec, csr_mepc, csr_mstatus;
  logic        lsu_busy;
  logic        wbu_csr_we;
  logic [11:0] wbu_csr_addr;
  logic [31:0] wbu_csr_wdata;
  logic        csr_we_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic        flush_o, busy_o, redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready;
  logic        wdog_fatal_o;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [31:0] data;
  } csr_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } rdr_exp_t;

  csr_exp_t csr_q[$];
  rdr_exp_t rdr_q[$];
  int cyc    = 0;
  int base   = 0;
  int errors = 0;
  int checks = 0;

  trap_ctrl #(.WDOG_CYCLES(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .excp_flush_i     (excp_flush),
    .mret_flush_i     (mret_flush),
    .mcause_i         (mcause),
    .mepc_i           (mepc),
    .csr_mtvec_i      (csr_mtvec),
    .csr_mepc_i       (csr_mepc),
    .csr_mstatus_i    (csr_mstatus),
    .lsu_busy_i       (lsu_busy),
    .wbu_csr_we_i     (wbu_csr_we),
    .wbu_csr_addr_i   (wbu_csr_addr),
    .wbu_csr_wdata_i  (wbu_csr_wdata),
    .csr_we_o         (csr_we_o),
    .csr_addr_o       (csr_addr_o),
    .csr_wdata_o      (csr_wdata_o),
    .flush_o          (flush_o),
    .busy_o           (busy_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready),
    .wdog_fatal_o     (wdog_fatal_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mstatus(input bit trap, input logic [31:0] m);
    if (trap) return (m & ~32'h0000_1888) | 32'h0000_1800 | (m[3] ? 32'h80 : 32'h0);
    return (m & ~32'h0000_1888) | 32'h0000_1880 | (m[7] ? 32'h8 : 32'h0);
  endfunction

  // Drives an event for cycle c0 and queues everything it should produce.
  // d = extra DRAIN cycles, r = extra REDIRECT cycles.
  task automatic applyStimulus(input bit trap, input bit mret, input logic [31:0] cause,
                               input logic [31:0] epc, input int d, input int r);
    base       = cyc;
    excp_flush = trap;
    mret_flush = mret;
    mcause     = cause;
    mepc       = epc;
    if (trap) begin
      csr_q.push_back('{base + 2 + d, 12'h341, epc});
      csr_q.push_back('{base + 3 + d, 12'h342, cause});
      csr_q.push_back('{base + 4 + d, 12'h300, model_mstatus(1'b1, csr_mstatus)});
      rdr_q.push_back('{base + 5 + d + r, {csr_mtvec[31:2], 2'b00}});
    end else if (mret) begin
      csr_q.push_back('{base + 2 + d, 12'h300, model_mstatus(1'b0, csr_mstatus)});
      rdr_q.push_back('{base + 3 + d + r, csr_mepc});
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Call from the start of c1; returns at the negedge of the first IDLE cycle.
  task automatic wait_idle(input int exp_cycle, input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy_o && n < 40);
    checkOutput(tag, cyc - base, exp_cycle);
  endtask

  always @(negedge clock) begin
    if (reset && csr_we_o) begin
      if (csr_q.size() == 0) begin
        checkOutput("csr_write_spurious", {31'd0, csr_we_o}, 32'd0);
      end else begin
        csr_exp_t e;
        e = csr_q.pop_front();
        checkOutput("csr_write_cycle", cyc, e.cyc);
        checkOutput("csr_write_addr", {20'd0, csr_addr_o}, {20'd0, e.addr});
        checkOutput("csr_write_data", csr_wdata_o, e.data);
      end
    end
    if (reset && redirect_valid_o && redirect_ready) begin
      if (rdr_q.size() == 0) begin
        checkOutput("redirect_spurious", {31'd0, redirect_valid_o}, 32'd0);
      end else begin
        rdr_exp_t e;
        e = rdr_q.pop_front();
        checkOutput("redirect_cycle", cyc, e.cyc);
        checkOutput("redirect_pc", redirect_pc_o, e.pc);
      end
    end
  end

  initial begin
    reset = 1'b1; excp_flush = 1'b0; mret_flush = 1'b0; mcause = '0; mepc = '0;
    csr_mtvec = '0; csr_mepc = '0; csr_mstatus = '0; lsu_busy = 1'b0;
    wbu_csr_we = 1'b0; wbu_csr_addr = '0; wbu_csr_wdata = '0; redirect_ready = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("reset_csr_we", {31'd0, csr_we_o}, 32'd0);
    checkOutput("reset_rvalid", {31'd0, redirect_valid_o}, 32'd0);
    checkOutput("reset_rpc", redirect_pc_o, 32'd0);
    checkOutput("reset_wdog", {31'd0, wdog_fatal_o}, 32'd0);
    checkOutput("reset_flush", {31'd0, flush_o}, 32'd0);
    reset = 1'b1;
    next_cycle();

    // ECALL trap with no stalls
    csr_mtvec = 32'h8000_0101; csr_mstatus = 32'h0000_0008;
    applyStimulus(1'b1, 1'b0, 32'd11, 32'h8000_0010, 0, 0);
    @(negedge clock);
    checkOutput("ecall_flush_c0", {31'd0, flush_o}, 32'd1);
    checkOutput("ecall_busy_c0", {31'd0, busy_o}, 32'd0);
    next_cycle();
    excp_flush = 1'b0;
    wait_idle(6, "ecall_idle_cycle");
    next_cycle();

    // MRET, then a simultaneous trap+mret in the first IDLE cycle (trap wins)
    csr_mepc = 32'h8000_0014; csr_mstatus = 32'h0000_0080;
    applyStimulus(1'b0, 1'b1, 32'd0, 32'd0, 0, 0);
    next_cycle();
    mret_flush = 1'b0;
    wait_idle(4, "mret_idle_cycle");
    csr_mstatus = 32'h0000_0000;
    applyStimulus(1'b1, 1'b1, 32'd3, 32'h8000_0040, 0, 0);
    next_cycle();
    excp_flush = 1'b0; mret_flush = 1'b0;
    wait_idle(6, "b2b_idle_cycle");
    next_cycle();

    // LSU drain stall for three cycles
    csr_mtvec = 32'h8000_0303; csr_mstatus = 32'hA5A5_A5AD; lsu_busy = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'd5, 32'h8000_0200, 3, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      checkOutput("stall_flush", {31'd0, flush_o}, 32'd1);
      next_cycle();
      if (k == 0) excp_flush = 1'b0;
      if (k == 3) lsu_busy = 1'b0;
    end
    wait_idle(9, "stall_idle_cycle");
    next_cycle();

    // Redirect back-pressure with an ignored second trap pulse
    redirect_ready = 1'b0; csr_mtvec = 32'h1000_0002; csr_mstatus = 32'h0;
    applyStimulus(1'b1, 1'b0, 32'd2, 32'h0000_0004, 0, 4);
    next_cycle();
    excp_flush = 1'b0;
    repeat (4) next_cycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checkOutput("bp_valid", {31'd0, redirect_valid_o}, 32'd1);
      checkOutput("bp_pc", redirect_pc_o, 32'h1000_0000);
      next_cycle();
      if (k == 1) begin
        excp_flush = 1'b1; mcause = 32'd9; mepc = 32'hDEAD_0000; csr_mtvec = 32'h2000_0000;
      end
      if (k == 2) excp_flush = 1'b0;
      if (k == 3) redirect_ready = 1'b1;
    end
    wait_idle(10, "bp_idle_cycle");
    next_cycle();

    // IDLE passthrough, then the same write colliding with a trap
    wbu_csr_we = 1'b1; wbu_csr_addr = 12'h305; wbu_csr_wdata = 32'h0000_1234;
    csr_q.push_back('{cyc, 12'h305, 32'h0000_1234});
    @(negedge clock);
    checkOutput("pt_we", {31'd0, csr_we_o}, 32'd1);
    next_cycle();
    csr_mtvec = 32'h8000_0000; csr_mstatus = 32'h0000_0008;
    applyStimulus(1'b1, 1'b0, 32'd7, 32'h8000_0400, 0, 0);
    @(negedge clock);
    checkOutput("collide_we", {31'd0, csr_we_o}, 32'd0);
    next_cycle();
    excp_flush = 1'b0; wbu_csr_we = 1'b0;
    wait_idle(6, "collide_idle_cycle");
    next_cycle();

    // Asynchronous reset while in W_MCAUSE
    applyStimulus(1'b1, 1'b0, 32'd1, 32'h8000_0500, 0, 0);
    next_cycle();
    excp_flush = 1'b0;
    next_cycle();
    next_cycle();
    #1 reset = 1'b0;
    #1;
    checkOutput("arst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("arst_csr_we", {31'd0, csr_we_o}, 32'd0);
    checkOutput("arst_rvalid", {31'd0, redirect_valid_o}, 32'd0);
    checkOutput("arst_rpc", redirect_pc_o, 32'd0);
    checkOutput("arst_flush", {31'd0, flush_o}, 32'd0);
    checkOutput("arst_pending_csr", csr_q.size(), 32'd2);
    checkOutput("arst_pending_rdr", rdr_q.size(), 32'd1);
    csr_q.delete();
    rdr_q.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    next_cycle();

    // Fresh MRET after reset
    csr_mepc = 32'h8000_0020; csr_mstatus = 32'hFFFF_FF77;
    applyStimulus(1'b0, 1'b1, 32'd0, 32'd0, 0, 0);
    next_cycle();
    mret_flush = 1'b0;
    wait_idle(4, "post_rst_mret_idle");
    next_cycle();

`ifdef TRAP_CTRL_WDOG_EN
    // LSU stuck busy: watchdog forces the exit after 8 DRAIN cycles
    lsu_busy = 1'b1; csr_mstatus = 32'h0000_0008; csr_mtvec = 32'h8000_0000;
    applyStimulus(1'b1, 1'b0, 32'd4, 32'h8000_0600, 7, 0);
    next_cycle();
    excp_flush = 1'b0;
    wait_idle(13, "wdog_idle_cycle");
    checkOutput("wdog_fatal", {31'd0, wdog_fatal_o}, 32'd1);
    lsu_busy = 1'b0;
    next_cycle();
`else
    checkOutput("wdog_fatal_tied", {31'd0, wdog_fatal_o}, 32'd0);
`endif

    repeat (2) @(negedge clock);
    checkOutput("csr_queue_empty", csr_q.size(), 32'd0);
    checkOutput("rdr_queue_empty", rdr_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
